// File: rtl/sa_request_generator.sv
// rtl/sa_request_generator.sv - switch-allocation request stage: per-input round-robin VC select,
// one-hot output-port request, grant-driven buffer reads and downstream credit tracking.
module sa_request_generator #(
  parameter int AGENTS_NUM    = 5,
  parameter int RESOURCES_NUM = 5,
  parameter int VC_NUM        = 2,
  parameter int BUFFER_SIZE   = 8,
  localparam int PW = (RESOURCES_NUM > 1) ? $clog2(RESOURCES_NUM) : 1,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [AGENTS_NUM-1:0][VC_NUM-1:0]             vc_valid_i,
  input  logic [AGENTS_NUM-1:0][VC_NUM-1:0][PW-1:0]     vc_out_port_i,
  input  logic [AGENTS_NUM-1:0][VC_NUM-1:0][VW-1:0]     vc_down_vc_i,
  input  logic [RESOURCES_NUM-1:0][VC_NUM-1:0]          credit_i,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      grants_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      requests_o,
  output logic [AGENTS_NUM-1:0][VW-1:0]                 vc_sel_o,
  output logic [AGENTS_NUM-1:0][VC_NUM-1:0]             flit_read_o,
  output logic                                          credit_overflow_o
);

  logic [RESOURCES_NUM-1:0][VC_NUM-1:0][CW-1:0] r_credits;
  logic [AGENTS_NUM-1:0][VW-1:0]                r_rr_ptr;
  logic                                         r_overflow;

  logic [AGENTS_NUM-1:0][VC_NUM-1:0]            w_elig;
  logic [AGENTS_NUM-1:0][VW-1:0]                w_sel;
  logic [AGENTS_NUM-1:0]                        w_any;
  logic [AGENTS_NUM-1:0]                        w_hit;
  logic [AGENTS_NUM-1:0][PW-1:0]                w_sel_port;
  logic [AGENTS_NUM-1:0][VW-1:0]                w_sel_dvc;
  logic [RESOURCES_NUM-1:0][VC_NUM-1:0]         w_dec;
  logic                                         w_ovf_set;
  logic [VW:0]                                  w_idx;

  // Out-of-range port or downstream-VC codes are treated as never eligible.
  always_comb begin
    w_elig = '0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_elig[a][v] = vc_valid_i[a][v]
                    && ({1'b0, vc_out_port_i[a][v]} < (PW+1)'(RESOURCES_NUM))
                    && ({1'b0, vc_down_vc_i[a][v]} < (VW+1)'(VC_NUM))
                    && (r_credits[vc_out_port_i[a][v]][vc_down_vc_i[a][v]] != '0);
      end
    end
  end

  always_comb begin
    w_sel       = r_rr_ptr;
    w_any       = '0;
    w_hit       = '0;
    w_sel_port  = '0;
    w_sel_dvc   = '0;
    w_idx       = '0;
    requests_o  = '0;
    vc_sel_o    = '0;
    flit_read_o = '0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      // Scan from the farthest offset down so the nearest eligible VC to rr_ptr wins.
      for (int k = VC_NUM - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_rr_ptr[a]} + (VW+1)'(k);
        if (w_idx >= (VW+1)'(VC_NUM)) w_idx = w_idx - (VW+1)'(VC_NUM);
        if (w_elig[a][w_idx[VW-1:0]]) begin
          w_any[a] = 1'b1;
          w_sel[a] = w_idx[VW-1:0];
        end
      end
      w_sel_port[a] = vc_out_port_i[a][w_sel[a]];
      w_sel_dvc[a]  = vc_down_vc_i[a][w_sel[a]];
      if (w_any[a] && !rst) requests_o[a][w_sel_port[a]] = 1'b1;
      w_hit[a] = |(requests_o[a] & grants_i[a]);
      if (w_hit[a]) flit_read_o[a][w_sel[a]] = 1'b1;
      vc_sel_o[a] = rst ? '0 : w_sel[a];
    end
  end

  always_comb begin
    w_dec     = '0;
    w_ovf_set = 1'b0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      if (w_hit[a]) w_dec[w_sel_port[a]][w_sel_dvc[a]] = 1'b1;
    end
    for (int r = 0; r < RESOURCES_NUM; r++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (credit_i[r][v] && !w_dec[r][v] && (r_credits[r][v] == CW'(BUFFER_SIZE)))
          w_ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        for (int v = 0; v < VC_NUM; v++) r_credits[r][v] <= CW'(BUFFER_SIZE);
      end
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (w_dec[r][v] && !credit_i[r][v])
            r_credits[r][v] <= r_credits[r][v] - CW'(1);
          else if (credit_i[r][v] && !w_dec[r][v] && (r_credits[r][v] != CW'(BUFFER_SIZE)))
            r_credits[r][v] <= r_credits[r][v] + CW'(1);
        end
      end
      for (int a = 0; a < AGENTS_NUM; a++) begin
        if (w_hit[a])
          r_rr_ptr[a] <= (w_sel[a] == VW'(VC_NUM - 1)) ? '0 : w_sel[a] + VW'(1);
      end
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign credit_overflow_o = r_overflow;

endmodule

// File: tb/tb_sa_request_generator.sv
// tb/tb_sa_request_generator.sv - directed and randomized checks of sa_request_generator
// against a queue/array-level reference model.
module tb_sa_request_generator;
  localparam int A = 5, R = 5, V = 2, B = 8, PW = 3, VW = 1;

  logic                         clk, rst;
  logic [A-1:0][V-1:0]          vc_valid_i;
  logic [A-1:0][V-1:0][PW-1:0]  vc_out_port_i;
  logic [A-1:0][V-1:0][VW-1:0]  vc_down_vc_i;
  logic [R-1:0][V-1:0]          credit_i;
  logic [A-1:0][R-1:0]          grants_i;
  logic [A-1:0][R-1:0]          requests_o;
  logic [A-1:0][VW-1:0]         vc_sel_o;
  logic [A-1:0][V-1:0]          flit_read_o;
  logic                         credit_overflow_o;

  int n_pass = 0, n_total = 0;
  int m_cred[R][V];
  int m_rr[A];
  bit m_ovf;
  logic [A-1:0][R-1:0]  exp_req;
  logic [A-1:0][VW-1:0] exp_sel;
  logic [A-1:0][V-1:0]  exp_read;

  sa_request_generator #(.AGENTS_NUM(A), .RESOURCES_NUM(R), .VC_NUM(V), .BUFFER_SIZE(B)) dut (
    .clk(clk), .rst(rst), .vc_valid_i(vc_valid_i), .vc_out_port_i(vc_out_port_i),
    .vc_down_vc_i(vc_down_vc_i), .credit_i(credit_i), .grants_i(grants_i),
    .requests_o(requests_o), .vc_sel_o(vc_sel_o), .flit_read_o(flit_read_o),
    .credit_overflow_o(credit_overflow_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_eval();
    for (int a = 0; a < A; a++) begin
      bit found;
      int s, v;
      found = 0;
      s = 0;
      exp_req[a] = '0;
      exp_read[a] = '0;
      exp_sel[a] = '0;
      if (!rst) begin
        exp_sel[a] = VW'(m_rr[a]);
        for (int k = 0; k < V; k++) begin
          v = (m_rr[a] + k) % V;
          if (!found && vc_valid_i[a][v] && m_cred[vc_out_port_i[a][v]][vc_down_vc_i[a][v]] > 0) begin
            found = 1;
            s = v;
          end
        end
        if (found) begin
          exp_sel[a] = VW'(s);
          exp_req[a][vc_out_port_i[a][s]] = 1'b1;
          if (grants_i[a][vc_out_port_i[a][s]]) exp_read[a][s] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_step();
    int dec[R][V];
    int s;
    if (rst) begin
      for (int r = 0; r < R; r++) for (int v = 0; v < V; v++) m_cred[r][v] = B;
      for (int a = 0; a < A; a++) m_rr[a] = 0;
      m_ovf = 0;
    end else begin
      for (int r = 0; r < R; r++) for (int v = 0; v < V; v++) dec[r][v] = 0;
      for (int a = 0; a < A; a++) begin
        if (exp_read[a] != '0) begin
          s = int'(exp_sel[a]);
          dec[vc_out_port_i[a][s]][vc_down_vc_i[a][s]]++;
          m_rr[a] = (s + 1) % V;
        end
      end
      for (int r = 0; r < R; r++) begin
        for (int v = 0; v < V; v++) begin
          if (dec[r][v] > 0 && !credit_i[r][v]) m_cred[r][v] -= dec[r][v];
          else if (credit_i[r][v] && dec[r][v] == 0) begin
            if (m_cred[r][v] == B) m_ovf = 1;
            else m_cred[r][v]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_eval();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vc_valid_i = '0; vc_out_port_i = '0; vc_down_vc_i = '0; credit_i = '0; grants_i = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  // Allocator-like grants: at most one agent per port, plus noise on unrequested ports.
  task automatic make_grants();
    int q[$];
    model_eval();
    grants_i = '0;
    for (int r = 0; r < R; r++) begin
      q.delete();
      for (int a = 0; a < A; a++) if (exp_req[a][r]) q.push_back(a);
      if (q.size() > 0 && ($urandom % 4) != 0) grants_i[q[$urandom % q.size()]][r] = 1'b1;
    end
    for (int a = 0; a < A; a++) grants_i[a] |= R'($urandom) & ~exp_req[a];
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1;
    vc_valid_i = '1; grants_i = '1;
    #1;
    n_total++; if (requests_o !== '0) $display("FAIL rst_active_req got %h exp 0", requests_o); else n_pass++;
    n_total++; if (flit_read_o !== '0) $display("FAIL rst_active_read got %h exp 0", flit_read_o); else n_pass++;
    tick();
    rst = 0;
    clear_inputs();
    #1;
    n_total++; if (requests_o !== '0) $display("FAIL reset_req got %h exp 0", requests_o); else n_pass++;
    n_total++; if (vc_sel_o !== '0) $display("FAIL reset_sel got %h exp 0", vc_sel_o); else n_pass++;
    n_total++; if (credit_overflow_o !== 1'b0) $display("FAIL reset_ovf got %b exp 0", credit_overflow_o); else n_pass++;
  endtask

  task automatic test_credit_exhaustion();
    int reads;
    do_reset();
    vc_valid_i[0][0] = 1'b1; vc_out_port_i[0][0] = 3'd2; vc_down_vc_i[0][0] = 1'b0;
    grants_i[0] = 5'b00100;
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      reads += int'(flit_read_o[0][0]);
      tick();
    end
    n_total++; if (reads != 8) $display("FAIL exhaust_reads got %0d exp 8", reads); else n_pass++;
    #1;
    n_total++; if (requests_o[0] !== 5'b0) $display("FAIL exhaust_req got %b exp 0", requests_o[0]); else n_pass++;
    credit_i[2][0] = 1'b1;
    #1;
    n_total++; if (requests_o[0] !== 5'b0) $display("FAIL credit_comb_path got %b exp 0", requests_o[0]); else n_pass++;
    tick();
    credit_i = '0;
    reads = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      reads += int'(flit_read_o[0][0]);
      tick();
    end
    n_total++; if (reads != 1) $display("FAIL refill_reads got %0d exp 1", reads); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [VW-1:0] e;
    do_reset();
    vc_valid_i[1] = 2'b11;
    vc_out_port_i[1][0] = 3'd1; vc_down_vc_i[1][0] = 1'b0;
    vc_out_port_i[1][1] = 3'd3; vc_down_vc_i[1][1] = 1'b1;
    grants_i[1] = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      e = VW'(i % 2);
      #1;
      n_total++; if (vc_sel_o[1] !== e) $display("FAIL rr_sel[%0d] got %0d exp %0d", i, vc_sel_o[1], e); else n_pass++;
      n_total++; if (flit_read_o[1] !== (e ? 2'b10 : 2'b01)) $display("FAIL rr_read[%0d] got %b exp onehot %0d", i, flit_read_o[1], e); else n_pass++;
      tick();
    end
    grants_i[1] = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (vc_sel_o[1] !== 1'b0) $display("FAIL rr_hold_sel[%0d] got %0d exp 0", i, vc_sel_o[1]); else n_pass++;
      n_total++; if (requests_o[1] !== 5'b00010 || flit_read_o[1] !== 2'b00)
        $display("FAIL rr_hold_req[%0d] got req %b read %b exp req 00010 read 00", i, requests_o[1], flit_read_o[1]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_ineligible_skip();
    do_reset();
    vc_valid_i[2][0] = 1'b1; vc_out_port_i[2][0] = 3'd4; vc_down_vc_i[2][0] = 1'b0;
    grants_i[2] = 5'b10000;
    repeat (8) tick();
    grants_i[2] = '0;
    vc_valid_i[3] = 2'b11;
    vc_out_port_i[3][0] = 3'd4; vc_down_vc_i[3][0] = 1'b0;
    vc_out_port_i[3][1] = 3'd0; vc_down_vc_i[3][1] = 1'b1;
    #1;
    n_total++; if (vc_sel_o[3] !== 1'b1) $display("FAIL skip_sel got %0d exp 1", vc_sel_o[3]); else n_pass++;
    n_total++; if (requests_o[3] !== 5'b00001) $display("FAIL skip_req got %b exp 00001", requests_o[3]); else n_pass++;
    n_total++; if (requests_o[2] !== 5'b00000) $display("FAIL skip_empty_req got %b exp 00000", requests_o[2]); else n_pass++;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    vc_valid_i[0][0] = 1'b1; vc_out_port_i[0][0] = 3'd1; vc_down_vc_i[0][0] = 1'b1;
    grants_i[0] = 5'b00010;
    repeat (7) tick();
    credit_i[1][1] = 1'b1;
    #1;
    n_total++; if (flit_read_o[0] !== 2'b01) $display("FAIL simul_read got %b exp 01", flit_read_o[0]); else n_pass++;
    tick();
    credit_i = '0;
    #1;
    n_total++; if (requests_o[0] !== 5'b00010) $display("FAIL simul_keep got %b exp 00010", requests_o[0]); else n_pass++;
    tick();
    #1;
    n_total++; if (requests_o[0] !== 5'b00000) $display("FAIL simul_drain got %b exp 00000", requests_o[0]); else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    int reads;
    do_reset();
    credit_i[3][1] = 1'b1;
    #1;
    n_total++; if (credit_overflow_o !== 1'b0) $display("FAIL ovf_early got %b exp 0", credit_overflow_o); else n_pass++;
    tick();
    credit_i = '0;
    #1;
    n_total++; if (credit_overflow_o !== 1'b1) $display("FAIL ovf_set got %b exp 1", credit_overflow_o); else n_pass++;
    vc_valid_i[4][1] = 1'b1; vc_out_port_i[4][1] = 3'd3; vc_down_vc_i[4][1] = 1'b1;
    grants_i[4] = 5'b01000;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      reads += int'(flit_read_o[4][1]);
      tick();
    end
    n_total++; if (reads != 8) $display("FAIL ovf_hold_reads got %0d exp 8", reads); else n_pass++;
    n_total++; if (credit_overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", credit_overflow_o); else n_pass++;
    do_reset();
    #1;
    n_total++; if (credit_overflow_o !== 1'b0) $display("FAIL ovf_clear got %b exp 0", credit_overflow_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    vc_valid_i = '1;
    for (int a = 0; a < A; a++)
      for (int v = 0; v < V; v++) begin
        vc_out_port_i[a][v] = PW'($urandom_range(0, R - 1));
        vc_down_vc_i[a][v]  = VW'($urandom % V);
      end
    repeat (5) begin
      make_grants();
      tick();
    end
    rst = 1;
    grants_i = '1;
    #1;
    n_total++; if (requests_o !== '0 || flit_read_o !== '0 || vc_sel_o !== '0)
      $display("FAIL mid_rst_outputs got req %h read %h sel %h exp 0", requests_o, flit_read_o, vc_sel_o); else n_pass++;
    tick();
    rst = 0;
    grants_i = '0;
    #1;
    model_eval();
    n_total++; if (vc_sel_o !== '0) $display("FAIL mid_rst_sel got %h exp 0", vc_sel_o); else n_pass++;
    n_total++; if (requests_o !== exp_req) $display("FAIL mid_rst_req got %h exp %h", requests_o, exp_req); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 60) == 0;
      vc_valid_i = (A*V)'($urandom);
      for (int a = 0; a < A; a++)
        for (int v = 0; v < V; v++) begin
          vc_out_port_i[a][v] = PW'($urandom_range(0, R - 1));
          vc_down_vc_i[a][v]  = VW'($urandom % V);
        end
      for (int r = 0; r < R; r++)
        for (int v = 0; v < V; v++) credit_i[r][v] = ($urandom % 8) == 0;
      make_grants();
      #1;
      n_total++; if (requests_o !== exp_req) $display("FAIL rnd_req[%0d] got %h exp %h", i, requests_o, exp_req); else n_pass++;
      n_total++; if (vc_sel_o !== exp_sel) $display("FAIL rnd_sel[%0d] got %h exp %h", i, vc_sel_o, exp_sel); else n_pass++;
      n_total++; if (flit_read_o !== exp_read) $display("FAIL rnd_read[%0d] got %h exp %h", i, flit_read_o, exp_read); else n_pass++;
      n_total++; if (credit_overflow_o !== m_ovf) $display("FAIL rnd_ovf[%0d] got %b exp %b", i, credit_overflow_o, m_ovf); else n_pass++;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    tick();
    test_reset();
    test_credit_exhaustion();
    test_round_robin();
    test_ineligible_skip();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sa_request_generator.md
# sa_request_generator

Switch-allocation request stage placed directly upstream of `separable_input_first_allocator`. For each router input port it selects one ready virtual channel (VC) per cycle using round-robin, and presents a one-hot output-port request to the allocator. It consumes the allocator's grants to issue buffer read strobes, and maintains per-output-port, per-downstream-VC credit counters that gate request eligibility.

## Interface
- `AGENTS_NUM`, 5, number of input ports (allocator agents)
- `RESOURCES_NUM`, 5, number of output ports (allocator resources)
- `VC_NUM`, 2, VCs per port
- `BUFFER_SIZE`, 8, downstream buffer depth per VC (initial credits)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `vc_valid_i`  in  [AGENTS_NUM][VC_NUM]  VC holds a flit and is in active (routed, VC-allocated) state
- `vc_out_port_i`  in  [AGENTS_NUM][VC_NUM][$clog2(RESOURCES_NUM)]  output port assigned to VC
- `vc_down_vc_i`  in  [AGENTS_NUM][VC_NUM][$clog2(VC_NUM)]  downstream VC assigned to VC
- `credit_i`  in  [RESOURCES_NUM][VC_NUM]  one-cycle credit return pulses from downstream
- `grants_i`  in  [AGENTS_NUM][RESOURCES_NUM]  allocator grants, same cycle as `requests_o`
- `requests_o`  out  [AGENTS_NUM][RESOURCES_NUM]  one-hot-or-zero request per agent, to `requests_i` of allocator
- `vc_sel_o`  out  [AGENTS_NUM][$clog2(VC_NUM)]  VC selected per agent
- `flit_read_o`  out  [AGENTS_NUM][VC_NUM]  one-hot read strobe to input buffers, asserted on grant
- `credit_overflow_o`  out  1  sticky error: credit returned to full counter

## Operation
- State: `credits[RESOURCES_NUM][VC_NUM]`, width $clog2(BUFFER_SIZE+1); `rr_ptr[AGENTS_NUM]`, width $clog2(VC_NUM); `credit_overflow_o`.
- A VC v of agent a is eligible when `vc_valid_i[a][v]` is set and `credits[vc_out_port_i[a][v]][vc_down_vc_i[a][v]] != 0`.
- Selection: the first eligible VC found scanning v = rr_ptr[a], rr_ptr[a]+1, ... modulo VC_NUM. `vc_sel_o[a]` is that VC. When nothing is eligible, `vc_sel_o[a]` = rr_ptr[a] and `requests_o[a]` = 0.
- `requests_o[a]` is the one-hot of `vc_out_port_i[a][vc_sel]` when any VC is eligible.
- A grant is honoured only when `grants_i[a][r]` and `requests_o[a][r]` are both set. Grant bits on unrequested ports are ignored.
- On an honoured grant:
  - `flit_read_o[a][vc_sel]` = 1 in the same cycle.
  - At the clock edge, `rr_ptr[a]` <= (vc_sel+1) mod VC_NUM.
  - At the clock edge, the credit at [r][vc_down_vc] is decremented.
- With no grant, `rr_ptr[a]` is unchanged.
- Credit update per counter at each edge:
  - decrement only: -1.
  - `credit_i` only: +1, unless the counter equals BUFFER_SIZE. In that case the counter holds and `credit_overflow_o` is set.
  - both in the same cycle: unchanged.
- The allocator grants each output port to at most one agent per cycle, so each counter sees at most one decrement per cycle.

## Timing
- `requests_o`, `vc_sel_o` and `flit_read_o` are combinational from registered state plus the current `vc_valid_i`, `vc_out_port_i`, `vc_down_vc_i` and `grants_i`.
- There are no combinational paths from `credit_i` to any output; credits affect eligibility from the next cycle.
- Grant-to-read latency is 0 cycles. A decrement is visible in eligibility one cycle after the grant.
- A VC with credit 1 that is granted in cycle N is ineligible in cycle N+1 unless a credit for that VC returns in cycle N.
- Reset, synchronous: all credits <= BUFFER_SIZE, all rr_ptr <= 0, `credit_overflow_o` <= 0.
- While `rst` is high, `requests_o` and `flit_read_o` are forced to 0 and `vc_sel_o` to 0.
- Reset asserted mid-operation discards in-flight state. Asserting reset during a grant cycle produces no read strobe.
- `credit_overflow_o` clears only on reset.

## Test plan
- Credit exhaustion: after reset, agent 0 VC0 valid to port 2, down VC 0, with grants_i echoing requests -> exactly 8 consecutive `flit_read_o[0][0]` pulses, then `requests_o[0]` = 0. One `credit_i[2][0]` pulse -> exactly one further request and grant.
- Round-robin: agent 1 with both VCs valid and granted every cycle -> `vc_sel_o[1]` alternates 0,1,0,1. With grants withheld -> `vc_sel_o[1]` stays constant.
- Ineligible skip: credits for VC0's target at 0 while VC1 is eligible -> VC1 is selected regardless of rr_ptr.
- Simultaneous events: a grant and a `credit_i` on the same counter in one cycle -> counter unchanged.
- Credit overflow: `credit_i` pulse with the counter at 8 -> counter stays 8 and `credit_overflow_o` = 1 and sticky until `rst`.
- Reset mid-traffic: `rst` for 1 cycle during continuous grants -> outputs 0 during reset, then all credits are 8 and all `vc_sel_o` are 0 on the first cycle after reset.
